// File: rtl/pl_pkg.sv
// ---------------------------------------------------------------------------
// pl_pkg -- definitions shared by all pipeline stages.
//   PL_DATA_W  : default payload width of a stage
//   PL_CNT_W   : default width of per-stage statistics counters
//   pl_state_e : occupancy state of a two-entry skid stage. The encoding
//                equals the number of payloads held, so it can be driven
//                straight onto an occupancy port.
// ---------------------------------------------------------------------------
package pl_pkg;

    localparam int PL_DATA_W = 32;
    localparam int PL_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pl_state_e;

endpackage

// File: rtl/pl_sat_cnt.sv
// ---------------------------------------------------------------------------
// pl_sat_cnt -- saturating up-counter.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once the count is all ones)
//   count : current count, sticks at 2^CNT_W-1
// ---------------------------------------------------------------------------
module pl_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pl_reg_skid.sv
// ---------------------------------------------------------------------------
// pl_reg_skid -- fully registered pipeline stage with a one-entry skid buffer.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   flush     : synchronous clear, overrides every other input
//   in_valid  : upstream payload valid
//   in_ready  : stage can take a payload (registered, no path from out_ready)
//   in_data   : upstream payload
//   out_valid : out_data holds a payload
//   out_ready : downstream takes out_data this cycle
//   out_data  : oldest held payload (main register)
//   occupancy : payloads held, 0..2
//   stall_cnt : saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module pl_reg_skid
    import pl_pkg::*;
#(
    parameter int                DATA_W   = PL_DATA_W,
    parameter logic [DATA_W-1:0] CLR_DATA = '0,
    parameter int                CNT_W    = PL_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    pl_state_e         state_q;
    pl_state_e         state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    // Per-register valid bits are pure decodes of the state: main is valid
    // in ONE and FULL, skid only in FULL.
    logic main_vld;
    logic skid_vld;
    logic accept;
    logic emit;
    logic stall_inc;

    assign main_vld = (state_q != ST_EMPTY);
    assign skid_vld = (state_q == ST_FULL);

    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_q;
    assign occupancy = state_q;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = CLR_DATA;
            skid_d  = CLR_DATA;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        // Pass-through: the new payload replaces the departing one.
                        main_d = in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the newcomer behind main.
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (emit) begin
                        // Drained: park out_data at the clear value.
                        main_d  = CLR_DATA;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only emit can happen.
                    if (emit) begin
                        main_d  = skid_q;
                        skid_d  = CLR_DATA;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = CLR_DATA;
                    skid_d  = CLR_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= CLR_DATA;
            skid_q  <= CLR_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Back-pressure statistic; flush deliberately does not clear it.
    assign stall_inc = out_valid && !out_ready;

    pl_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pl_reg_skid.sv
module tb_pl_reg_skid;

    localparam int          DATA_W    = 32;
    localparam int          CNT_W     = 4;
    localparam logic [31:0] CLR       = 32'hDEAD_BEEF;
    localparam int          STALL_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    pl_reg_skid #(
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two payloads plus a stall tally.
    logic [DATA_W-1:0] ref_q[$];
    int                ref_stall;
    bit                pristine;   // no accept since last reset/flush
    bit                verbose;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at/just after a falling edge. Drives inputs, checks outputs
    // against the model, advances the model over the next rising edge and
    // returns at the following falling edge.
    task automatic step(input bit iv, input logic [DATA_W-1:0] d, input bit ordy, input bit fl);
        bit acc;
        bit emi;
        logic [DATA_W-1:0] head;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("occupancy", occupancy, ref_q.size());
        chk("out_valid", out_valid, ref_q.size() > 0);
        chk("in_ready",  in_ready,  ref_q.size() < 2);
        chk("stall_cnt", stall_cnt, ref_stall);
        if (ref_q.size() > 0) chk("out_data", out_data, ref_q[0]);
        else if (pristine)    chk("out_data_clr", out_data, CLR);
        @(posedge clk);
        acc  = iv && (ref_q.size() < 2);
        emi  = ordy && (ref_q.size() > 0);
        head = (ref_q.size() > 0) ? ref_q[0] : CLR;
        if (ref_q.size() > 0 && !ordy && ref_stall < STALL_MAX) ref_stall++;
        if (fl) begin
            ref_q.delete();
            pristine = 1'b1;
        end else begin
            if (emi) void'(ref_q.pop_front());
            if (acc) begin
                ref_q.push_back(d);
                pristine = 1'b0;
            end
        end
        if (verbose && (acc || emi || fl))
            $display("txn t=%0t acc=%0b in=%h emit=%0b out=%h flush=%0b occ_next=%0d",
                     $time, acc, d, emi, head, fl, ref_q.size());
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks the immediate effect, releases at
    // a falling edge so the next step's accept lands on the first rising edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_occupancy", occupancy, 2'd0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_data",  out_data,  CLR);
        chk("rst_stall_cnt", stall_cnt, 0);
        ref_q.delete();
        ref_stall = 0;
        pristine  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        verbose = 1'b1;
        ref_stall = 0;
        pristine = 1'b1;
        do_reset();

        // Streaming with out_ready high: one per cycle, latency 1.
        for (int i = 1; i <= 8; i++) step(1'b1, 32'hA000_0000 + i, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure: fill to FULL, hold, then drain in order.
        do_reset();
        step(1'b1, 32'hB000_0001, 1'b0, 1'b0);
        step(1'b1, 32'hB000_0002, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hBBBB_0000 + i, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush in FULL with in_valid and out_ready also high.
        step(1'b1, 32'hC000_0001, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0002, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0003, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Stall counter saturation with CNT_W = 4.
        do_reset();
        step(1'b1, 32'hD000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("stall_sat", stall_cnt, STALL_MAX);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset while FULL, then accept right after release.
        step(1'b1, 32'hE000_0001, 1'b0, 1'b0);
        step(1'b1, 32'hE000_0002, 1'b0, 1'b0);
        #1;
        chk("pre_rst_full", occupancy, 2'd2);
        do_reset();
        step(1'b1, 32'hE000_0003, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic against the reference queue.
        verbose = 1'b0;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pl_reg_skid.md
PL_REG_SKID -- requirements
Module: pl_reg_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of the stage payload (data plus control fields).
REQ-002 Parameter CLR_DATA, default 0, payload value loaded on reset or flush.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 flush  input  1  synchronous pipeline clear.
REQ-007 in_valid  input  1  upstream stage holds a valid payload.
REQ-008 in_ready  output  1  stage can accept a payload this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  downstream stage accepts out_data this cycle.
REQ-012 out_data  output  DATA_W  payload to the next stage.
REQ-013 occupancy  output  2  number of payloads held (0..2).
REQ-014 stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-015 Storage SHALL be two payload registers: main (drives out_data) and skid, each with its own valid bit.
REQ-016 States SHALL be EMPTY (no payload), ONE (main valid), FULL (main and skid valid); occupancy SHALL encode 0/1/2 respectively.
REQ-017 in_ready SHALL equal "state != FULL" and SHALL depend only on registered state, with no combinational path from out_ready.
REQ-018 Accept SHALL be in_valid && in_ready; emit SHALL be out_valid && out_ready; out_valid SHALL equal "state != EMPTY".
REQ-019 EMPTY: on accept, load main and go to ONE; latency from accept to out_valid SHALL be 1 cycle.
REQ-020 ONE: on accept with emit, load main and stay in ONE; on accept without emit, load skid and go to FULL; on emit without accept, go to EMPTY.
REQ-021 FULL: on emit, move skid into main and go to ONE; in_ready is 0, so no accept occurs.
REQ-022 Ordering SHALL be strict FIFO; main always holds the oldest payload; there is no loss or duplication.
REQ-023 Sustained throughput SHALL be one payload per cycle while out_ready = 1.
REQ-024 flush SHALL dominate all other inputs: the next state is EMPTY, both registers are loaded with CLR_DATA, and a payload accepted or emitted in the flush cycle is discarded for the stage.
REQ-025 out_data SHALL equal CLR_DATA whenever out_valid = 0 after reset or flush.
REQ-026 stall_cnt SHALL increment by 1 in each cycle with out_valid && !out_ready, SHALL saturate at 2^CNT_W-1, and SHALL be unaffected by flush.
REQ-027 out_data, out_valid, in_ready and occupancy SHALL be driven directly from registers or state decode; out_ready SHALL reach no output combinationally.

Reset
REQ-028 While rst = 1: state EMPTY, out_valid = 0, in_ready = 1, occupancy = 0, out_data = CLR_DATA, stall_cnt = 0.
REQ-029 Reset asserted mid-transfer SHALL discard all held payloads immediately, without waiting for a clock edge.
REQ-030 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-031 Package pl_pkg SHALL hold the state enumeration (EMPTY/ONE/FULL) and the default DATA_W/CNT_W constants shared by all pipeline stages.
REQ-032 The saturating counter SHALL be the sub-module pl_sat_cnt (parameter CNT_W; ports clk, rst, inc, count).
REQ-033 pl_reg_skid SHALL contain no other sub-modules.

Verification
REQ-034 Stream A1..A8 with out_ready = 1 -> out_data A1..A8 on consecutive cycles, each 1 cycle after accept; occupancy = 1; stall_cnt = 0.
REQ-035 Accept A1, A2 with out_ready = 0 -> occupancy = 2, in_ready = 0, stall_cnt increments each cycle; raise out_ready -> A1 then A2 emitted, in_ready = 1 after A1 leaves.
REQ-036 In FULL, assert flush together with in_valid and out_ready -> next cycle state EMPTY, out_valid = 0, out_data = CLR_DATA, and neither payload appears later.
REQ-037 CNT_W = 4, hold out_valid = 1 and out_ready = 0 for 20 cycles -> stall_cnt = 15 and holds.
REQ-038 Assert rst asynchronously between edges while in FULL -> out_valid = 0 and occupancy = 0 immediately, in_ready = 1; after release, the next accept appears 1 cycle later.
REQ-039 Random valid/ready at 50% for 10,000 cycles, checked against a reference queue -> ordering identical, no loss or duplication, occupancy never exceeds 2.
